// File: rtl/csr_access_arbiter_pkg.sv
// csr_arb_pkg: shared types and constants for the CSR access arbiter
package csr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int CSR_AW = 16;
  localparam int CSR_DW = 32;
  localparam logic [CSR_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/csr_access_arbiter_if.sv
// csr_access_arbiter_if: requester-side and CSR-side bus of the arbiter
interface csr_access_arbiter_if #(parameter int NUM_REQ = 2);
  import csr_arb_pkg::*;
  logic [NUM_REQ-1:0] req_read;
  logic [NUM_REQ-1:0] req_write;
  logic [NUM_REQ*CSR_AW-1:0] req_addr;
  logic [NUM_REQ*CSR_DW-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [CSR_DW-1:0] rsp_rdata;
  logic rsp_err;
  logic [CSR_AW-1:0] csr_addr;
  logic csr_wr_en;
  logic csr_rd_en;
  logic [CSR_DW-1:0] csr_wdata;
  logic [CSR_DW-1:0] csr_rdata;
  logic csr_rd_dvalid;
  logic busy;
  logic stray_dvalid;
  modport slave (
    input req_read, req_write, req_addr, req_wdata, csr_rdata, csr_rd_dvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, csr_addr, csr_wr_en, csr_rd_en, csr_wdata, busy, stray_dvalid
  );
  modport master (
    output req_read, req_write, req_addr, req_wdata, csr_rdata, csr_rd_dvalid,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, csr_addr, csr_wr_en, csr_rd_en, csr_wdata, busy, stray_dvalid
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just above the last grant
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int IW = $clog2(NUM_REQ);
  // scan from farthest to nearest so the nearest active index above i_last wins
  always_comb begin
    o_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (i_req[(int'(i_last) + i) % NUM_REQ]) o_idx = IW'((int'(i_last) + i) % NUM_REQ);
    o_any = |i_req;
    o_gnt = o_any ? NUM_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: round-robin sharing of one CSR port with read timeout
module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [CSR_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic clk,
  input logic rst,
  csr_access_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e r_state, w_next;
  logic [IW-1:0] r_last, r_gnt, w_idx;
  logic [NUM_REQ-1:0] w_gnt, w_act;
  logic w_any;
  logic [CSR_AW-1:0] r_addr;
  logic [CSR_DW-1:0] r_wdata, r_rdata;
  logic r_wr, r_err, r_stray;
  logic [CW-1:0] r_cnt;
  assign w_act = bus.req_read | bus.req_write;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req (w_act),
    .i_last(r_last),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // latched transaction, wait counter, response data and stray flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_gnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_stray <= 1'b0;
    end else begin
      r_stray <= r_stray | (bus.csr_rd_dvalid && r_state != WAIT);
      r_cnt   <= r_state == ISSUE ? '0 : r_state == WAIT ? r_cnt + 1'b1 : r_cnt;
      if (r_state == IDLE && w_any) begin
        r_gnt   <= w_idx;
        r_last  <= w_idx;
        r_addr  <= bus.req_addr[w_idx*CSR_AW +: CSR_AW];
        r_wdata <= bus.req_wdata[w_idx*CSR_DW +: CSR_DW];
        r_wr    <= bus.req_write[w_idx];
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
      if (r_state == WAIT && bus.csr_rd_dvalid) begin
        r_rdata <= bus.csr_rdata;
        r_err   <= 1'b0;
      end else if (r_state == WAIT && r_cnt == LAST) begin
        r_rdata <= ERR_DATA;
        r_err   <= 1'b1;
      end
    end
  end
  // next state and state-decoded outputs; accept is masked while reset is held
  always_comb begin
    w_next = r_state == IDLE  ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE ? (r_wr ? RESP : WAIT) :
             r_state == WAIT  ? ((bus.csr_rd_dvalid || r_cnt == LAST) ? RESP : WAIT) : IDLE;
    bus.req_ready = (r_state == IDLE && !rst) ? w_gnt : '0;
    bus.rsp_valid = r_state == RESP ? NUM_REQ'(1) << r_gnt : '0;
    bus.rsp_rdata = r_state == RESP ? r_rdata : '0;
    bus.rsp_err   = r_state == RESP && r_err;
    bus.csr_wr_en = r_state == ISSUE && r_wr;
    bus.csr_rd_en = r_state == ISSUE && !r_wr;
    bus.busy      = r_state != IDLE;
  end
  assign bus.csr_addr     = r_addr;
  assign bus.csr_wdata    = r_wdata;
  assign bus.stray_dvalid = r_stray;
endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb_csr_access_arbiter: randomized transactions checked against a transaction-level model
module tb_csr_access_arbiter;
  localparam int N = 2;
  localparam int TO = 64;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic pr[N];
  logic pw[N];
  logic [15:0] pa[N];
  logic [31:0] pd[N];
  int last = N - 1;
  int win;
  csr_access_arbiter_if #(.NUM_REQ(N)) bus();
  csr_access_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_read[i]  = pr[i];
      bus.req_write[i] = pw[i];
      bus.req_addr[i*16 +: 16]  = pa[i];
      bus.req_wdata[i*32 +: 32] = pd[i];
    end
  endtask
  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pr[i] = 1'b0;
      pw[i] = 1'b0;
      pa[i] = 16'h0;
      pd[i] = 32'h0;
    end
  endtask
  task automatic refill(input int i);
    int r;
    r = $urandom_range(0, 5);
    pr[i] = (r < 2) || (r == 4);
    pw[i] = (r == 2) || (r == 3) || (r == 4);
    pa[i] = 16'($urandom);
    pd[i] = $urandom;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_wr"}, 32'(bus.csr_wr_en), 32'h0);
    chk({tag, "_rd"}, 32'(bus.csr_rd_en), 32'h0);
  endtask
  // one complete transaction: k = cycle of dvalid after the read strobe (k > TO means none)
  task automatic txn(input int k, input logic [31:0] rd, output int w);
    logic wr;
    logic [15:0] a;
    logic [31:0] d;
    int n;
    w = -1;
    for (int i = 1; i <= N; i++)
      if (w < 0 && (pr[(last + i) % N] || pw[(last + i) % N])) w = (last + i) % N;
    wr = pw[w];
    a = pa[w];
    d = pd[w];
    @(negedge clk);
    drive_reqs();
    bus.csr_rd_dvalid = 1'b0;
    #1;
    chk("ready", 32'(bus.req_ready), 32'(1 << w));
    chk("busy_idle", 32'(bus.busy), 32'h0);
    last = w;
    pr[w] = 1'b0;
    pw[w] = 1'b0;
    @(negedge clk);
    drive_reqs();
    #1;
    chk("wr_en", 32'(bus.csr_wr_en), 32'(wr));
    chk("rd_en", 32'(bus.csr_rd_en), 32'(!wr));
    chk("addr", 32'(bus.csr_addr), 32'(a));
    chk("wdata", bus.csr_wdata, d);
    chk("busy_issue", 32'(bus.busy), 32'h1);
    chk("ready_busy", 32'(bus.req_ready), 32'h0);
    if (!wr) begin
      n = k > TO ? TO : k;
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        bus.csr_rd_dvalid = (c == k);
        bus.csr_rdata = (c == k) ? rd : $urandom;
        #1;
        chk("busy_wait", 32'(bus.busy), 32'h1);
        chk("rspv_wait", 32'(bus.rsp_valid), 32'h0);
        chk("strobe_wait", 32'({bus.csr_wr_en, bus.csr_rd_en}), 32'h0);
      end
    end
    @(negedge clk);
    bus.csr_rd_dvalid = 1'b0;
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << w));
    chk("rsp_rdata", bus.rsp_rdata, wr ? 32'h0 : (k <= TO ? rd : ERR));
    chk("rsp_err", 32'(bus.rsp_err), 32'(!wr && k > TO));
    chk("busy_resp", 32'(bus.busy), 32'h1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    int prev;
    int k;
    bus.csr_rdata = '0;
    bus.csr_rd_dvalid = 1'b0;
    clear_reqs();
    pw[0] = 1'b1;
    drive_reqs();
    #1;
    check_idle_outputs("rst");
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_stray", 32'(bus.stray_dvalid), 32'h0);
    chk("rst_addr", 32'(bus.csr_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_reqs();
    drive_reqs();
    pw[0] = 1'b1; pa[0] = 16'h0030; pd[0] = 32'h1234_5678;
    txn(0, 32'h0, win);
    pr[1] = 1'b1; pa[1] = 16'h0010; pd[1] = 32'h0;
    txn(3, 32'hCAFE_0001, win);
    pr[0] = 1'b1; pa[0] = 16'h0044;
    txn(TO + 6, 32'h0, win);
    pr[1] = 1'b1; pa[1] = 16'h0048;
    txn(TO, 32'h5A5A_0064, win);
    pr[0] = 1'b1; pw[0] = 1'b1; pa[0] = 16'h0050; pd[0] = 32'h0BAD_F00D;
    txn(2, 32'h1111_2222, win);
    prev = last;
    for (int i = 0; i < N; i++) begin
      pw[i] = 1'b1;
      pa[i] = 16'($urandom);
      pd[i] = $urandom;
    end
    for (int t = 0; t < 6; t++) begin
      txn(0, 32'h0, win);
      chk("fair", 32'(win), 32'((prev + 1) % N));
      prev = win;
      pw[win] = 1'b1;
      pa[win] = 16'($urandom);
      pd[win] = $urandom;
    end
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 7);
      k = k == 0 ? TO : k == 1 ? TO + 1 + int'($urandom_range(0, 4)) : int'($urandom_range(1, 8));
      txn(k, $urandom, win);
      refill(win);
      if (!(pr[0] || pw[0] || pr[1] || pw[1])) pr[$urandom_range(0, N - 1)] = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("no_stray", 32'(bus.stray_dvalid), 32'h0);
    clear_reqs();
    pr[0] = 1'b1; pa[0] = 16'h0070;
    @(negedge clk);
    drive_reqs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_addr", 32'(bus.csr_addr), 32'h0);
    chk("mid_rst_rdata", bus.rsp_rdata, 32'h0);
    chk("mid_rst_err", 32'(bus.rsp_err), 32'h0);
    @(negedge clk);
    clear_reqs();
    drive_reqs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.csr_rd_dvalid = 1'b1;
    bus.csr_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.csr_rd_dvalid = 1'b0;
    #1;
    chk("stray", 32'(bus.stray_dvalid), 32'h1);
    check_idle_outputs("post_stray");
    chk("post_stray_busy", 32'(bus.busy), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
